mc14500_core: RTL and testbench
===============================

MC14500_CORE -- requirements
Module: mc14500_core

Interface
REQ-001 Parameter SIZE_LOG, default 8, data-RAM address width; matches the data RAM's SIZE_LOG.
REQ-002 Parameter PROG_LOG, default 8, program-ROM address width.
REQ-003 Port clk  in  1  single system clock; all state changes on rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port prog_addr  out  PROG_LOG  program counter driven to the combinational program ROM.
REQ-006 Port prog_data  in  4+SIZE_LOG  instruction word; [SIZE_LOG+3:SIZE_LOG] opcode, [SIZE_LOG-1:0] operand address.
REQ-007 Port address  out  SIZE_LOG  data-RAM address.
REQ-008 Port write  out  1  data-RAM write strobe; RAM captures on its rising edge.
REQ-009 Port data_out  out  1  store data to RAM data_in.
REQ-010 Port data_in  in  1  read data from RAM data_out; valid while write low and address stable.
REQ-011 Port flag_o / flag_f  out  1 each  one-cycle pulses for NOP0 / NOPF.
REQ-012 Port rr  out  1  result register, for observation.

Function
REQ-013 The core SHALL sequence states FETCH -> EXEC -> FETCH for non-store instructions (2 cycles each).
REQ-014 Store instructions SHALL sequence FETCH -> EXEC -> ST_SETUP -> ST_STROBE -> ST_HOLD -> FETCH (5 cycles).
REQ-015 FETCH: prog_addr = pc; instruction register captures prog_data at cycle end; pc increments mod 2^PROG_LOG (0xFF -> 0x00).
REQ-016 EXEC and all store states: address = captured operand, held constant; write = 0 except ST_STROBE.
REQ-017 ST_STROBE SHALL drive write = 1 for exactly one cycle; data_out stable from ST_SETUP through ST_HOLD.
REQ-018 Gated data d = ien ? data_in : 0, sampled in EXEC.
REQ-019 Opcodes: 0 NOP0 flag_o pulse; 1 LD rr=d; 2 LDC rr=~d; 3 AND rr&=d; 4 ANDC rr&=~d; 5 OR rr|=d; 6 ORC rr|=~d; 7 XNOR rr=~(rr^d).
REQ-020 Opcodes: 8 STO data_out=rr; 9 STOC data_out=~rr; store path entered only if oen = 1, otherwise EXEC -> FETCH, write never asserted.
REQ-021 Opcodes: A IEN ien=data_in (ungated); B OEN oen=data_in (ungated).
REQ-022 Opcode C JMP: ret = pc (already incremented), pc = operand zero-extended/truncated to PROG_LOG.
REQ-023 Opcode D RTN: pc = ret, skip = 1.
REQ-024 Opcode E SKZ: skip = 1 if rr == 0.
REQ-025 Opcode F NOPF: flag_f pulse.
REQ-026 If skip = 1 in EXEC, the instruction SHALL be discarded (no register, pc, flag or RAM effect), skip cleared, 2 cycles.
REQ-027 flag_o/flag_f SHALL be high only during the EXEC-following cycle (one cycle) of the matching instruction.

Reset
REQ-028 rst_n low at a clk edge SHALL force: state FETCH, pc 0, rr 0, ien 1, oen 1, skip 0, ret 0, write 0, data_out 0, flags 0.
REQ-029 Reset mid-store SHALL drop write to 0 on the same edge; an aborted strobe never re-issues.

Structure
REQ-030 Package mc14500_pkg SHALL hold the opcode enum (4-bit), the state enum, and instruction field width constants.
REQ-031 One combinational sub-module mc14500_lu SHALL compute next rr and store data from opcode, rr, d.

Verification
REQ-032 Reset, ROM {LD 0x07}, data_in=1 -> rr=1 after 2 cycles; prog_addr 0 -> 1.
REQ-033 OEN=1, rr=1, STO 0x02 -> address=0x02 for 3 cycles, write high only in the middle cycle, data_out=1.
REQ-034 OEN 0x10 with data_in=0 then STO 0x02 -> write never asserts; next fetch 1 cycle after EXEC.
REQ-035 IEN with data_in=0, then LD with data_in=1 -> rr=0.
REQ-036 rr=0, SKZ, LDC, NOPF -> LDC discarded (rr stays 0), flag_f pulses once.
REQ-037 JMP 0x40 at pc 0x05, then RTN at 0x40 -> pc 0x06 after JMP return, instruction at 0x06 skipped, executed from 0x07; rst_n low during ST_STROBE -> write 0 next cycle, pc 0.

Source files
------------

// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500 one-bit industrial control core.
package mc14500_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP0 = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_ST_SETUP,
        S_ST_STROBE,
        S_ST_HOLD
    } state_e;

endpackage

// File: rtl/mc14500_lu.sv
// Logic unit: next result register and store data for the current opcode.
module mc14500_lu
    import mc14500_pkg::*;
(
    input  op_e  op_i,
    input  logic rr_i,
    input  logic d_i,
    output logic rr_o,
    output logic sto_o
);

    always_comb begin
        rr_o = rr_i;
        unique case (op_i)
            OP_LD:   rr_o = d_i;
            OP_LDC:  rr_o = ~d_i;
            OP_AND:  rr_o = rr_i & d_i;
            OP_ANDC: rr_o = rr_i & ~d_i;
            OP_OR:   rr_o = rr_i | d_i;
            OP_ORC:  rr_o = rr_i | ~d_i;
            OP_XNOR: rr_o = ~(rr_i ^ d_i);
            default: rr_o = rr_i;
        endcase
    end

    assign sto_o = (op_i == OP_STOC) ? ~rr_i : rr_i;

endmodule

// File: rtl/mc14500_core.sv
// MC14500 core: 2-cycle fetch/execute, 5-cycle store with a centred write strobe.
module mc14500_core
    import mc14500_pkg::*;
#(
    parameter int SIZE_LOG = 8,
    parameter int PROG_LOG = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [PROG_LOG-1:0]       prog_addr,
    input  logic [OPC_W+SIZE_LOG-1:0] prog_data,
    output logic [SIZE_LOG-1:0]       address,
    output logic                      write,
    output logic                      data_out,
    input  logic                      data_in,
    output logic                      flag_o,
    output logic                      flag_f,
    output logic                      rr
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [SIZE_LOG-1:0] addr_q, addr_d;
    logic [PROG_LOG-1:0] pc_q, pc_d, ret_q, ret_d;
    logic rr_q, rr_d, ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
    logic dout_q, dout_d, fo_q, fo_d, ff_q, ff_d;
    logic d, lu_rr, lu_sto;

    assign d = ien_q ? data_in : 1'b0;

    mc14500_lu u_lu (
        .op_i (op_q),
        .rr_i (rr_q),
        .d_i  (d),
        .rr_o (lu_rr),
        .sto_o(lu_sto)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_NOP0;
            addr_q  <= '0;
            pc_q    <= '0;
            ret_q   <= '0;
            rr_q    <= 1'b0;
            ien_q   <= 1'b1;
            oen_q   <= 1'b1;
            skip_q  <= 1'b0;
            dout_q  <= 1'b0;
            fo_q    <= 1'b0;
            ff_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            rr_q    <= rr_d;
            ien_q   <= ien_d;
            oen_q   <= oen_d;
            skip_q  <= skip_d;
            dout_q  <= dout_d;
            fo_q    <= fo_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        rr_d    = rr_q;
        ien_d   = ien_q;
        oen_d   = oen_q;
        skip_d  = skip_q;
        dout_d  = dout_q;
        fo_d    = 1'b0;
        ff_d    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                op_d    = op_e'(prog_data[SIZE_LOG+OPC_W-1:SIZE_LOG]);
                addr_d  = prog_data[SIZE_LOG-1:0];
                pc_d    = pc_q + PROG_LOG'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    unique case (op_q)
                        OP_NOP0: fo_d = 1'b1;
                        OP_LD, OP_LDC, OP_AND, OP_ANDC,
                        OP_OR, OP_ORC, OP_XNOR: rr_d = lu_rr;
                        OP_STO, OP_STOC: begin
                            // With outputs disabled the store collapses to a plain 2-cycle op.
                            if (oen_q) begin
                                dout_d  = lu_sto;
                                state_d = S_ST_SETUP;
                            end
                        end
                        OP_IEN: ien_d = data_in;
                        OP_OEN: oen_d = data_in;
                        OP_JMP: begin
                            ret_d = pc_q;
                            pc_d  = PROG_LOG'(addr_q);
                        end
                        OP_RTN: begin
                            pc_d   = ret_q;
                            skip_d = 1'b1;
                        end
                        OP_SKZ:  skip_d = ~rr_q;
                        OP_NOPF: ff_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_ST_SETUP:  state_d = S_ST_STROBE;
            S_ST_STROBE: state_d = S_ST_HOLD;
            S_ST_HOLD:   state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // Strobe decoded from the state register, so a reset edge kills it immediately.
    assign write     = (state_q == S_ST_STROBE);
    assign prog_addr = pc_q;
    assign address   = addr_q;
    assign data_out  = dout_q;
    assign flag_o    = fo_q;
    assign flag_f    = ff_q;
    assign rr        = rr_q;

endmodule

// File: tb/tb_mc14500_core.sv
// Directed bench for mc14500_core: opcode table plus store, skip, jump and reset sequences.
module tb_mc14500_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  prog_addr;
    logic [11:0] prog_data;
    logic [7:0]  address;
    logic        write, data_out, data_in, flag_o, flag_f, rr;

    logic [11:0] rom [0:255];
    logic        ram [0:255];
    int nvec = 0, nerr = 0, wcnt = 0, ffcnt = 0;

    always #5 clk = ~clk;

    assign prog_data = rom[prog_addr];

    mc14500_core #(.SIZE_LOG(8), .PROG_LOG(8)) dut (
        .clk(clk), .rst_n(rst_n), .prog_addr(prog_addr), .prog_data(prog_data),
        .address(address), .write(write), .data_out(data_out), .data_in(data_in),
        .flag_o(flag_o), .flag_f(flag_f), .rr(rr)
    );

    always @(posedge write) begin
        wcnt++;
        ram[address] <= data_out;
    end

    always @(posedge clk) if (flag_f === 1'b1) ffcnt++;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic       di;
        logic       e_rr;
        logic       e_fo;
        logic       e_ff;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    task automatic release_rst();
        run(2);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic di, input logic e_rr,
                                input logic e_fo, input logic e_ff);
        vec_t v;
        v.op = op; v.a = 8'h07; v.di = di; v.e_rr = e_rr; v.e_fo = e_fo; v.e_ff = e_ff;
        return v;
    endfunction

    int w0, f0;

    initial begin
        data_in = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 1'b0;

        vt[0]  = mk(4'h1, 1'b1, 1'b1, 1'b0, 1'b0); // LD
        vt[1]  = mk(4'h3, 1'b0, 1'b0, 1'b0, 1'b0); // AND
        vt[2]  = mk(4'h6, 1'b0, 1'b1, 1'b0, 1'b0); // ORC
        vt[3]  = mk(4'h4, 1'b1, 1'b0, 1'b0, 1'b0); // ANDC
        vt[4]  = mk(4'h5, 1'b1, 1'b1, 1'b0, 1'b0); // OR
        vt[5]  = mk(4'h7, 1'b1, 1'b1, 1'b0, 1'b0); // XNOR
        vt[6]  = mk(4'h7, 1'b0, 1'b0, 1'b0, 1'b0); // XNOR
        vt[7]  = mk(4'h2, 1'b0, 1'b1, 1'b0, 1'b0); // LDC
        vt[8]  = mk(4'h2, 1'b1, 1'b0, 1'b0, 1'b0); // LDC
        vt[9]  = mk(4'hA, 1'b0, 1'b0, 1'b0, 1'b0); // IEN off
        vt[10] = mk(4'h1, 1'b1, 1'b0, 1'b0, 1'b0); // LD gated
        vt[11] = mk(4'h6, 1'b1, 1'b1, 1'b0, 1'b0); // ORC gated
        vt[12] = mk(4'hA, 1'b1, 1'b1, 1'b0, 1'b0); // IEN on
        vt[13] = mk(4'h0, 1'b0, 1'b1, 1'b1, 1'b0); // NOP0
        vt[14] = mk(4'hF, 1'b0, 1'b1, 1'b0, 1'b1); // NOPF

        // Program A: opcode table
        rom_clear();
        for (int i = 0; i < 15; i++) rom[i] = {vt[i].op, vt[i].a};
        release_rst();
        chk("rst_pc", prog_addr, 0);
        chk("rst_rr", rr, 0);
        chk("rst_write", write, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_flags", {flag_o, flag_f}, 0);
        for (int i = 0; i < 15; i++) begin
            data_in = vt[i].di;
            run(2);
            chk($sformatf("v%0d_rr", i), rr, vt[i].e_rr);
            chk($sformatf("v%0d_fo", i), flag_o, vt[i].e_fo);
            chk($sformatf("v%0d_ff", i), flag_f, vt[i].e_ff);
            chk($sformatf("v%0d_pc", i), prog_addr, i + 1);
        end

        // Program B: store, disabled store, skip
        rst_n = 1'b0;
        rom_clear();
        rom[0] = 12'h100; rom[1] = 12'h802; rom[2] = 12'hB10; rom[3] = 12'h802;
        rom[4] = 12'h100; rom[5] = 12'hE00; rom[6] = 12'h200; rom[7] = 12'hF00;
        release_rst();
        data_in = 1'b1;
        run(2);
        chk("B_ld_rr", rr, 1);
        w0 = wcnt;
        run(1);
        chk("sto_exec_addr", address, 8'h02);
        chk("sto_exec_wr", write, 0);
        run(1);
        chk("sto_setup_addr", address, 8'h02);
        chk("sto_setup_wr", write, 0);
        chk("sto_setup_dout", data_out, 1);
        run(1);
        chk("sto_strobe_addr", address, 8'h02);
        chk("sto_strobe_wr", write, 1);
        chk("sto_strobe_dout", data_out, 1);
        run(1);
        chk("sto_hold_addr", address, 8'h02);
        chk("sto_hold_wr", write, 0);
        chk("sto_hold_dout", data_out, 1);
        run(1);
        chk("sto_next_pc", prog_addr, 2);
        chk("sto_wcnt", wcnt, w0 + 1);
        chk("sto_ram", ram[2], 1);
        data_in = 1'b0;
        run(2);
        chk("oen_pc", prog_addr, 3);
        w0 = wcnt;
        run(1);
        chk("oen_sto_exec_wr", write, 0);
        run(1);
        chk("oen_sto_fetch_pc", prog_addr, 4);
        chk("oen_sto_wr", write, 0);
        run(2); // LD 0 must execute immediately after the dropped store
        chk("oen_ld_rr", rr, 0);
        chk("oen_wcnt", wcnt, w0);
        f0 = ffcnt;
        run(2); // SKZ
        run(2); // LDC skipped
        chk("skz_rr", rr, 0);
        chk("skz_ff", flag_f, 0);
        chk("skz_pc", prog_addr, 7);
        run(2); // NOPF
        chk("nopf_ff", flag_f, 1);
        run(1);
        chk("nopf_ff_end", flag_f, 0);
        chk("nopf_once", ffcnt, f0 + 1);

        // Program C: jump/return/skip, reset during strobe
        rst_n = 1'b0;
        rom_clear();
        rom[0] = 12'h100; rom[5] = 12'hC40; rom[8'h40] = 12'hD00;
        rom[6] = 12'h200; rom[7] = 12'h805;
        release_rst();
        data_in = 1'b1;
        run(2);
        chk("C_ld_rr", rr, 1);
        run(8);
        chk("C_pre_jmp_pc", prog_addr, 5);
        run(2);
        chk("jmp_pc", prog_addr, 8'h40);
        run(2);
        chk("rtn_pc", prog_addr, 8'h06);
        run(2);
        chk("rtn_skip_pc", prog_addr, 8'h07);
        chk("rtn_skip_rr", rr, 1);
        w0 = wcnt;
        run(3);
        chk("abort_strobe_wr", write, 1);
        rst_n = 1'b0;
        run(1);
        chk("abort_wr", write, 0);
        chk("abort_pc", prog_addr, 0);
        chk("abort_rr", rr, 0);
        chk("abort_dout", data_out, 0);
        rst_n = 1'b1;
        run(6);
        chk("abort_no_reissue", wcnt, w0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
